io_panel_pio: RTL and testbench
===============================

# io_panel_pio

Parametrised front-panel I/O peripheral that replaces the separate fixed-width HEX, LED, switch and pushbutton PIOs of the Qsys system with one memory-mapped slave. It debounces switches and pushbuttons, captures button-press edges with an optional interrupt, drives LEDs, and encodes per-digit hex values into active-low seven-segment patterns. It sits on the HPS/Nios lightweight bus, with its export ports going straight to board pins.

## Interface
- NUM_DIGITS, 6, number of seven-segment digits (1..8)
- NUM_SWITCHES, 10, slide switch count (1..32)
- NUM_BUTTONS, 4, pushbutton count (1..32)
- NUM_LEDS, 10, LED count (1..32)
- DEBOUNCE_CYCLES, 50000, stable cycles required before a debounced input changes (≥1)
- clk_clk  in  1  the block's single clock
- reset_reset  in  1  synchronous, active-high reset
- avs_address  in  3  word address
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_readdata  out  32  read data, fixed latency 1
- irq  out  1  level interrupt, registered
- switches_export  in  NUM_SWITCHES  raw switches, 1 = up
- pushbuttons_export  in  NUM_BUTTONS  raw keys, active-low (0 = pressed)
- hex_export  out  7*NUM_DIGITS  segments, active-low; digit k on [7k+6:7k], bit 0 = segment a … bit 6 = g
- rled_export  out  NUM_LEDS  LEDs, 1 = lit

## Operation
- Register map (word address): 0 HEX_VAL (RW, nibble k = digit k); 1 HEX_BLANK (RW, bit k = 1 blanks digit k); 2 LED (RW); 3 SW (RO, debounced); 4 BTN (RO, debounced, 1 = pressed); 5 EDGE (RW1C, press edges); 6 IRQ_MASK (RW); 7 reserved, reads 0.
- Bits beyond the configured width read 0; writes to them, to RO registers and to address 7 are ignored.
- Input path per bit: 2-FF synchroniser -> debouncer. Button input is inverted after synchronisation. Debouncer counter increments while the synchronised value differs from the debounced value. It clears to 0 on any cycle they match. When the counter equals DEBOUNCE_CYCLES-1 and the values still differ, the debounced value takes the synchronised value and the counter clears.
- EDGE bit k sets on a 0->1 transition of debounced BTN bit k. A write to EDGE with bit k = 1 clears it. If set and clear occur in the same cycle, set wins.
- irq register = |(EDGE & IRQ_MASK), updated every cycle.
- Segment encoding for a digit not blanked: 0->0x40, 1->0x79, 2->0x24, 3->0x30, 4->0x19, 5->0x12, 6->0x02, 7->0x78, 8->0x00, 9->0x10, A->0x08, b->0x03, C->0x46, d->0x21, E->0x06, F->0x0E. A blanked digit outputs 0x7F. hex_export is registered.
- Reset values: HEX_VAL 0; HEX_BLANK all ones; LED 0; SW 0; BTN 0; EDGE 0; IRQ_MASK 0; irq 0; avs_readdata 0; hex_export all ones; rled_export 0. Synchroniser stages reset to 0 for switches and to 1 (released) for buttons. All debounce counters reset to 0.
- Reset asserted mid-debounce discards the partial count, and no edge is captured afterwards.

## Timing
- Write: register updates on the clock edge where avs_write = 1. rled_export changes on that same edge. hex_export changes one cycle later.
- Read: avs_readdata is valid on the edge after avs_read = 1 and holds until the next read. Simultaneous read and write to the same address returns the old value.
- Input latency: a raw edge held stable reaches SW/BTN DEBOUNCE_CYCLES+2 clocks later. EDGE sets in the same cycle BTN rises. irq rises one cycle after EDGE sets.
- A glitch shorter than DEBOUNCE_CYCLES synchronised cycles never reaches SW/BTN.
- The W1C clear of EDGE takes effect on the write edge. irq falls one cycle later.

## Configuration
- IO_PANEL_PIO_IRQ_EN defined: EDGE capture, IRQ_MASK and irq logic are present as described.
- IO_PANEL_PIO_IRQ_EN undefined: irq tied 0; EDGE and IRQ_MASK read 0 and ignore writes. BTN still works as polled state.

## Test plan
- Reset, then read all 8 addresses -> HEX_BLANK = 0x3F, the others 0. hex_export all ones, rled_export 0, irq 0.
- DEBOUNCE_CYCLES = 4: toggle switch 3 high -> SW reads 0x008 after exactly 6 clocks. A 3-cycle pulse on switch 5 -> SW never shows bit 5.
- Write HEX_VAL = 0x00A3F1, then HEX_BLANK = 0x20 -> digits 0..4 = 0x79, 0x0E, 0x30, 0x08, 0x40; digit 5 = 0x7F.
- IRQ_EN on, IRQ_MASK = 0x2, press key 1 (pin low) for 10 cycles -> BTN = 0x2, EDGE = 0x2, irq = 1. Write EDGE = 0x2 -> EDGE = 0 and irq = 0 one cycle later. Release -> no new edge.
- Assert EDGE clear on the same cycle a new press edge on that bit is detected -> EDGE bit remains 1.
- Assert reset during a press with the counter at 2 of 4 -> BTN, EDGE, irq stay 0. Post-reset debounce restarts from 0.

Source files
------------

// File: rtl/io_panel_pio.sv
// Front-panel PIO: debounced switches/buttons, LEDs, 7-seg hex, press-edge IRQ.
// Define IO_PANEL_PIO_IRQ_EN to include EDGE capture, IRQ_MASK and irq.
module io_panel_pio_deb #(
  parameter int W        = 1,
  parameter int D        = 1,
  parameter bit SYNC_ONE = 1'b0,
  parameter bit INV      = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] raw,
  output logic [W-1:0] deb,
  output logic [W-1:0] rise
);
  localparam int CW = $clog2(D + 1);
  localparam logic [CW-1:0] LAST = CW'(D - 1);

  logic [W-1:0]  s1, s2, syn;
  logic [CW-1:0] cnt [W];

  assign syn = INV ? ~s2 : s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1  <= {W{SYNC_ONE}};
      s2  <= {W{SYNC_ONE}};
      deb <= '0;
      for (int i = 0; i < W; i++) cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < W; i++) begin
        if (syn[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == LAST) begin
          deb[i] <= syn[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // A debounced 0->1 happens exactly when the counter saturates on a 1
  always_comb begin
    rise = '0;
    for (int i = 0; i < W; i++)
      rise[i] = syn[i] & ~deb[i] & (cnt[i] == LAST);
  end
endmodule

module io_panel_pio #(
  parameter int NUM_DIGITS      = 6,
  parameter int NUM_SWITCHES    = 10,
  parameter int NUM_BUTTONS     = 4,
  parameter int NUM_LEDS        = 10,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                      clk_clk,
  input  logic                      reset_reset,
  input  logic [2:0]                avs_address,
  input  logic                      avs_read,
  input  logic                      avs_write,
  input  logic [31:0]               avs_writedata,
  output logic [31:0]               avs_readdata,
  output logic                      irq,
  input  logic [NUM_SWITCHES-1:0]   switches_export,
  input  logic [NUM_BUTTONS-1:0]    pushbuttons_export,
  output logic [7*NUM_DIGITS-1:0]   hex_export,
  output logic [NUM_LEDS-1:0]       rled_export
);
  localparam int HW = 4 * NUM_DIGITS;

  logic [HW-1:0]           hex_val;
  logic [NUM_DIGITS-1:0]   hex_blank;
  logic [NUM_SWITCHES-1:0] sw_deb, sw_rise;
  logic [NUM_BUTTONS-1:0]  btn_deb, btn_rise;
  logic [NUM_BUTTONS-1:0]  edge_q, mask_q;
  logic [31:0]             rd;
  logic                    unused_bits;

  assign unused_bits = ^{avs_writedata, sw_rise};

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  io_panel_pio_deb #(
    .W(NUM_SWITCHES), .D(DEBOUNCE_CYCLES),
    .SYNC_ONE(1'b0), .INV(1'b0)
  ) u_sw (
    .clk(clk_clk), .rst(reset_reset), .raw(switches_export),
    .deb(sw_deb), .rise(sw_rise)
  );

  // Keys are active-low at the pin; sync stages idle at "released"
  io_panel_pio_deb #(
    .W(NUM_BUTTONS), .D(DEBOUNCE_CYCLES),
    .SYNC_ONE(1'b1), .INV(1'b1)
  ) u_btn (
    .clk(clk_clk), .rst(reset_reset), .raw(pushbuttons_export),
    .deb(btn_deb), .rise(btn_rise)
  );

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      hex_val     <= '0;
      hex_blank   <= '1;
      rled_export <= '0;
      hex_export  <= '1;
    end else begin
      if (avs_write) begin
        case (avs_address)
          3'd0: hex_val     <= avs_writedata[HW-1:0];
          3'd1: hex_blank   <= avs_writedata[NUM_DIGITS-1:0];
          3'd2: rled_export <= avs_writedata[NUM_LEDS-1:0];
          default: ;
        endcase
      end
      for (int k = 0; k < NUM_DIGITS; k++)
        hex_export[7*k +: 7] <= hex_blank[k] ? 7'h7F : seg7(hex_val[4*k +: 4]);
    end
  end

`ifdef IO_PANEL_PIO_IRQ_EN
  logic [NUM_BUTTONS-1:0] clr;

  assign clr = (avs_write && avs_address == 3'd5) ?
               avs_writedata[NUM_BUTTONS-1:0] : '0;

  // Set is OR'd in after the clear so a same-cycle press survives
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      edge_q <= '0;
      mask_q <= '0;
      irq    <= 1'b0;
    end else begin
      edge_q <= (edge_q & ~clr) | btn_rise;
      if (avs_write && avs_address == 3'd6)
        mask_q <= avs_writedata[NUM_BUTTONS-1:0];
      irq <= |(edge_q & mask_q);
    end
  end
`else
  logic unused_rise;

  assign unused_rise = |btn_rise;
  assign edge_q = '0;
  assign mask_q = '0;
  assign irq    = 1'b0;
`endif

  always_comb begin
    rd = '0;
    case (avs_address)
      3'd0: rd = 32'(hex_val);
      3'd1: rd = 32'(hex_blank);
      3'd2: rd = 32'(rled_export);
      3'd3: rd = 32'(sw_deb);
      3'd4: rd = 32'(btn_deb);
      3'd5: rd = 32'(edge_q);
      3'd6: rd = 32'(mask_q);
      default: rd = '0;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) avs_readdata <= '0;
    else if (avs_read) avs_readdata <= rd;
  end
endmodule

// File: tb/tb_io_panel_pio.sv
// Directed bench for io_panel_pio with a short debounce window.
// Expectations for EDGE/IRQ_MASK/irq follow IO_PANEL_PIO_IRQ_EN.
module tb_io_panel_pio;
  localparam int ND = 6;
  localparam int NS = 10;
  localparam int NB = 4;
  localparam int NL = 10;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    addr;
  logic          rd_en;
  logic          wr_en;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          irq;
  logic [NS-1:0] sw;
  logic [NB-1:0] keys;
  logic [7*ND-1:0] hex;
  logic [NL-1:0] led;

  int checks   = 0;
  int failures = 0;

`ifdef IO_PANEL_PIO_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  io_panel_pio #(
    .NUM_DIGITS(ND), .NUM_SWITCHES(NS), .NUM_BUTTONS(NB),
    .NUM_LEDS(NL), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk_clk(clk),
    .reset_reset(rst),
    .avs_address(addr),
    .avs_read(rd_en),
    .avs_write(wr_en),
    .avs_writedata(wdata),
    .avs_readdata(rdata),
    .irq(irq),
    .switches_export(sw),
    .pushbuttons_export(keys),
    .hex_export(hex),
    .rled_export(led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en = 1'b1;
    addr  = a;
    wdata = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    rd_en = 1'b1;
    addr  = a;
    @(negedge clk);
    rd_en = 1'b0;
    d = rdata;
  endtask

  logic [31:0] v;
  logic [41:0] exp_hex;
  logic [31:0] exp_reset [8];
  logic        bad;

  initial begin
    rst   = 1'b1;
    addr  = '0;
    rd_en = 1'b0;
    wr_en = 1'b0;
    wdata = '0;
    sw    = '0;
    keys  = '1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_hex", 64'(hex), 64'h3FF_FFFF_FFFF);
    chk("rst_led", 64'(led), 64'h0);
    chk("rst_irq", 64'(irq), 64'h0);
    chk("rst_rdata", 64'(rdata), 64'h0);
    for (int i = 0; i < 8; i++) exp_reset[i] = 32'h0;
    exp_reset[1] = 32'h3F;
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), v);
      chk($sformatf("rst_reg%0d", i), 64'(v), 64'(exp_reset[i]));
    end

    // Switch 3: debounced value appears 6 clocks after the pin change
    @(negedge clk);
    sw[3] = 1'b1;
    rd_en = 1'b1;
    addr  = 3'd3;
    repeat (6) @(negedge clk);
    chk("sw_not_yet", 64'(rdata), 64'h0);
    @(negedge clk);
    chk("sw_latency", 64'(rdata), 64'h008);

    // 3-cycle glitch on switch 5 never reaches SW
    sw[5] = 1'b1;
    repeat (3) @(negedge clk);
    sw[5] = 1'b0;
    bad = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (rdata[5]) bad = 1'b1;
    end
    rd_en = 1'b0;
    chk("sw_glitch", 64'(bad), 64'h0);
    rd(3'd3, v);
    chk("sw_final", 64'(v), 64'h008);

    // LED register: lit on the write edge, upper bits dropped
    wr(3'd2, 32'hFFFF_FFFF);
    chk("led_now", 64'(led), 64'h3FF);
    rd(3'd2, v);
    chk("led_rd", 64'(v), 64'h3FF);
    wr(3'd2, 32'h155);
    chk("led_155", 64'(led), 64'h155);

    // Read and write same address in one cycle returns old value
    @(negedge clk);
    rd_en = 1'b1;
    wr_en = 1'b1;
    addr  = 3'd2;
    wdata = 32'h0AA;
    @(negedge clk);
    rd_en = 1'b0;
    wr_en = 1'b0;
    chk("rw_old", 64'(rdata), 64'h155);
    chk("rw_led", 64'(led), 64'h0AA);

    // RO and reserved writes are ignored
    wr(3'd3, 32'hFFFF_FFFF);
    rd(3'd3, v);
    chk("sw_ro", 64'(v), 64'h008);
    wr(3'd7, 32'hFFFF_FFFF);
    rd(3'd7, v);
    chk("rsvd", 64'(v), 64'h0);

    // Hex digits
    wr(3'd0, 32'h00A3F1);
    @(negedge clk);
    chk("hex_blanked", 64'(hex), 64'h3FF_FFFF_FFFF);
    wr(3'd1, 32'h20);
    chk("hex_lag", 64'(hex), 64'h3FF_FFFF_FFFF);
    @(negedge clk);
    exp_hex = {7'h7F, 7'h40, 7'h08, 7'h30, 7'h0E, 7'h79};
    chk("hex_digits", 64'(hex), 64'(exp_hex));
    rd(3'd0, v);
    chk("hexval_rd", 64'(v), 64'h00A3F1);
    rd(3'd1, v);
    chk("blank_rd", 64'(v), 64'h20);
    wr(3'd0, 32'hFFFF_FFFF);
    rd(3'd0, v);
    chk("hexval_wide", 64'(v), 64'hFF_FFFF);

    // Key 1 press with mask 0x2
    wr(3'd6, 32'hFFFF_FFF2);
    rd(3'd6, v);
    chk("mask_rd", 64'(v), IRQ_ON ? 64'h2 : 64'h0);
    @(negedge clk);
    keys[1] = 1'b0;
    repeat (6) @(negedge clk);
    chk("irq_early", 64'(irq), 64'h0);
    @(negedge clk);
    chk("irq_rise", 64'(irq), IRQ_ON ? 64'h1 : 64'h0);
    repeat (3) @(negedge clk);
    rd(3'd4, v);
    chk("btn_press", 64'(v), 64'h2);
    rd(3'd5, v);
    chk("edge_set", 64'(v), IRQ_ON ? 64'h2 : 64'h0);
    wr(3'd5, 32'h2);
    chk("irq_hold", 64'(irq), IRQ_ON ? 64'h1 : 64'h0);
    @(negedge clk);
    chk("irq_fall", 64'(irq), 64'h0);
    rd(3'd5, v);
    chk("edge_clr", 64'(v), 64'h0);
    keys[1] = 1'b1;
    repeat (10) @(negedge clk);
    rd(3'd4, v);
    chk("btn_release", 64'(v), 64'h0);
    rd(3'd5, v);
    chk("edge_release", 64'(v), 64'h0);
    chk("irq_release", 64'(irq), 64'h0);

    // Clear on the same edge as a new press: set wins
    keys[1] = 1'b0;
    repeat (5) @(negedge clk);
    wr_en = 1'b1;
    addr  = 3'd5;
    wdata = 32'h2;
    @(negedge clk);
    wr_en = 1'b0;
    rd(3'd5, v);
    chk("edge_set_wins", 64'(v), IRQ_ON ? 64'h2 : 64'h0);
    keys[1] = 1'b1;
    repeat (10) @(negedge clk);
    wr(3'd5, 32'hF);

    // Reset halfway through a key 2 debounce
    keys[2] = 1'b0;
    repeat (4) @(negedge clk);
    rst  = 1'b1;
    keys = '1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_rdata", 64'(rdata), 64'h0);
    chk("mid_rst_led", 64'(led), 64'h0);
    repeat (10) @(negedge clk);
    rd(3'd4, v);
    chk("mid_rst_btn", 64'(v), 64'h0);
    rd(3'd5, v);
    chk("mid_rst_edge", 64'(v), 64'h0);
    chk("mid_rst_irq", 64'(irq), 64'h0);
    rd(3'd6, v);
    chk("mid_rst_mask", 64'(v), 64'h0);

    // Fresh press after reset takes the full debounce time
    @(negedge clk);
    keys[2] = 1'b0;
    rd_en = 1'b1;
    addr  = 3'd4;
    repeat (6) @(negedge clk);
    chk("post_rst_early", 64'(rdata), 64'h0);
    @(negedge clk);
    chk("post_rst_btn", 64'(rdata), 64'h4);
    rd_en = 1'b0;
    keys  = '1;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
